// File: rtl/sudoku_pkg.sv
// Shared command codes, FSM state type and wrap-around helpers for the
// Sudoku input sequencer.
package sudoku_pkg;

   localparam int GRID_N_DEFAULT = 9;
   localparam int NUM_CMDS       = 9;

   localparam logic [3:0] CMD_UP        = 4'd0;
   localparam logic [3:0] CMD_DOWN      = 4'd1;
   localparam logic [3:0] CMD_LEFT      = 4'd2;
   localparam logic [3:0] CMD_RIGHT     = 4'd3;
   localparam logic [3:0] CMD_DIG_INC   = 4'd4;
   localparam logic [3:0] CMD_DIG_DEC   = 4'd5;
   localparam logic [3:0] CMD_PLACE     = 4'd6;
   localparam logic [3:0] CMD_ERASE     = 4'd7;
   localparam logic [3:0] CMD_CLEAR_ERR = 4'd8;

   typedef enum logic {ST_IDLE, ST_WRITE} state_t;

   function automatic logic [3:0] wrap_inc(input logic [3:0] v, input logic [3:0] lo,
                                           input logic [3:0] hi);
      return (v >= hi) ? lo : v + 4'd1;
   endfunction

   function automatic logic [3:0] wrap_dec(input logic [3:0] v, input logic [3:0] lo,
                                           input logic [3:0] hi);
      return (v <= lo) ? hi : v - 4'd1;
   endfunction

endpackage

// File: rtl/sudoku_input_sequencer_cmd_fifo.sv
// Small synchronous command FIFO with flush; a pop on an empty FIFO is
// ignored even when a push lands at the same edge (no fall-through).
module cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic [CW-1:0] count_next,
   output logic          empty,
   output logic          full,
   output logic          pop_ok
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          push_ok;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CW'(DEPTH));
   assign pop_ok  = pop && !empty && !flush;
   // A full FIFO still accepts a push when the head leaves at the same edge.
   assign push_ok = push && !flush && (!full || pop_ok);
   assign count_next = flush ? '0 : count_reg + CW'(push_ok) - CW'(pop_ok);
   assign dout    = mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (!reset || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         count_reg <= count_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset && push_ok) mem[wr_ptr_reg] <= din;
   end

endmodule

// File: rtl/sudoku_input_sequencer.sv
// Turns debounced button pulses into cursor/digit/board-write commands:
// priority arbitration, command FIFO, and a two-state execute FSM.
module sudoku_input_sequencer
   import sudoku_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int GRID_N     = GRID_N_DEFAULT,
   parameter int DROP_W     = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [11:0]       btn_pulse,
   output logic              block_controller,
   output logic [3:0]        cursor_row,
   output logic [3:0]        cursor_col,
   output logic [3:0]        sel_digit,
   output logic              wr_valid,
   output logic [3:0]        wr_row,
   output logic [3:0]        wr_col,
   output logic [3:0]        wr_digit,
   input  logic              wr_ready,
   input  logic              wr_reject,
   output logic              error_flag,
   output logic [DROP_W-1:0] drop_count,
   output logic              busy
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [3:0] POS_MAX = 4'(GRID_N - 1);
   localparam logic [3:0] DIG_MAX = 4'(GRID_N);

   state_t            state_reg;
   logic [3:0]        row_reg, col_reg, digit_reg;
   logic [3:0]        wr_row_reg, wr_col_reg, wr_digit_reg;
   logic              wr_valid_reg, error_reg, block_reg;
   logic [DROP_W-1:0] drop_reg;

   logic [NUM_CMDS-1:0] valid;
   logic [3:0]          push_cmd;
   logic [3:0]          n_valid;
   logic                push_any;
   logic [3:0]          head_cmd;
   logic [CW-1:0]       count_next;
   logic                fifo_empty, fifo_full, pop_ok;
   logic [3:0]          drop_inc;
   logic [DROP_W:0]     drop_sum;
   logic [DROP_W-1:0]   drop_next;
   logic                unused_btns;

   assign unused_btns = ^btn_pulse[11:9];
   assign valid       = enable ? btn_pulse[NUM_CMDS-1:0] : '0;
   assign push_any    = |valid;

   always_comb begin
      push_cmd = '0;
      n_valid  = '0;
      for (int i = NUM_CMDS - 1; i >= 0; i--) begin
         if (valid[i]) begin
            push_cmd = 4'(i);
            n_valid  = n_valid + 4'd1;
         end
      end
   end

   cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(4)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .flush      (!enable),
      .push       (push_any),
      .pop        (state_reg == ST_IDLE),
      .din        (push_cmd),
      .dout       (head_cmd),
      .count_next (count_next),
      .empty      (fifo_empty),
      .full       (fifo_full),
      .pop_ok     (pop_ok)
   );

   // Losers of arbitration plus a push bounced off a full FIFO.
   assign drop_inc  = push_any ? (n_valid - 4'd1 + {3'b000, fifo_full && !pop_ok}) : 4'd0;
   assign drop_sum  = {1'b0, drop_reg} + (DROP_W + 1)'(drop_inc);
   assign drop_next = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg    <= ST_IDLE;
         row_reg      <= '0;
         col_reg      <= '0;
         digit_reg    <= 4'd1;
         wr_valid_reg <= 1'b0;
         wr_row_reg   <= '0;
         wr_col_reg   <= '0;
         wr_digit_reg <= '0;
         error_reg    <= 1'b0;
         drop_reg     <= '0;
         block_reg    <= 1'b1;
      end else begin
         drop_reg  <= drop_next;
         block_reg <= !enable || (count_next >= CW'(FIFO_DEPTH - 1));
         case (state_reg)
            ST_IDLE: begin
               if (pop_ok) begin
                  case (head_cmd)
                     CMD_UP:        row_reg   <= wrap_dec(row_reg, 4'd0, POS_MAX);
                     CMD_DOWN:      row_reg   <= wrap_inc(row_reg, 4'd0, POS_MAX);
                     CMD_LEFT:      col_reg   <= wrap_dec(col_reg, 4'd0, POS_MAX);
                     CMD_RIGHT:     col_reg   <= wrap_inc(col_reg, 4'd0, POS_MAX);
                     CMD_DIG_INC:   digit_reg <= wrap_inc(digit_reg, 4'd1, DIG_MAX);
                     CMD_DIG_DEC:   digit_reg <= wrap_dec(digit_reg, 4'd1, DIG_MAX);
                     CMD_PLACE, CMD_ERASE: begin
                        wr_row_reg   <= row_reg;
                        wr_col_reg   <= col_reg;
                        wr_digit_reg <= (head_cmd == CMD_PLACE) ? digit_reg : 4'd0;
                        wr_valid_reg <= 1'b1;
                        state_reg    <= ST_WRITE;
                     end
                     CMD_CLEAR_ERR: error_reg <= 1'b0;
                     default: ;
                  endcase
               end
            end
            ST_WRITE: begin
               if (wr_ready) begin
                  wr_valid_reg <= 1'b0;
                  if (wr_reject) error_reg <= 1'b1;
                  state_reg <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign block_controller = block_reg;
   assign cursor_row       = row_reg;
   assign cursor_col       = col_reg;
   assign sel_digit        = digit_reg;
   assign wr_valid         = wr_valid_reg;
   assign wr_row           = wr_row_reg;
   assign wr_col           = wr_col_reg;
   assign wr_digit         = wr_digit_reg;
   assign error_flag       = error_reg;
   assign drop_count       = drop_reg;
   assign busy             = (state_reg != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_sudoku_input_sequencer.sv
// Directed plus randomized bench for sudoku_input_sequencer, checked every
// cycle against a queue-based command model.
module tb_sudoku_input_sequencer;

   localparam int DEPTH    = 4;
   localparam int DROP_MAX = 255;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic [11:0] btn_pulse = '0;
   logic        wr_ready = 1'b0;
   logic        wr_reject = 1'b0;
   logic        block_controller, wr_valid, error_flag, busy;
   logic [3:0]  cursor_row, cursor_col, sel_digit, wr_row, wr_col, wr_digit;
   logic [7:0]  drop_count;

   int tests = 0;
   int fails = 0;

   int q[$];
   int m_row, m_col, m_dig, m_wv, m_wr, m_wc, m_wd, m_err, m_drop, m_blk, m_inw;

   sudoku_input_sequencer #(.FIFO_DEPTH(DEPTH), .GRID_N(9), .DROP_W(8)) dut (
      .clk              (clk),
      .reset            (reset),
      .enable           (enable),
      .btn_pulse        (btn_pulse),
      .block_controller (block_controller),
      .cursor_row       (cursor_row),
      .cursor_col       (cursor_col),
      .sel_digit        (sel_digit),
      .wr_valid         (wr_valid),
      .wr_row           (wr_row),
      .wr_col           (wr_col),
      .wr_digit         (wr_digit),
      .wr_ready         (wr_ready),
      .wr_reject        (wr_reject),
      .error_flag       (error_flag),
      .drop_count       (drop_count),
      .busy             (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input logic [11:0] btn, input bit en, input bit rdy,
                             input bit rej, input bit rst);
      bit pop;
      int cmd;
      int nv;
      int first;
      if (!rst) begin
         q.delete();
         m_row = 0; m_col = 0; m_dig = 1;
         m_wv = 0; m_wr = 0; m_wc = 0; m_wd = 0;
         m_err = 0; m_drop = 0; m_blk = 1; m_inw = 0;
         return;
      end
      cmd = -1;
      pop = en && !m_inw && (q.size() > 0);
      if (pop) cmd = q.pop_front();
      if (en) begin
         nv = 0;
         first = -1;
         for (int i = 0; i < 9; i++) begin
            if (btn[i]) begin
               nv++;
               if (first < 0) first = i;
            end
         end
         if (nv > 0) begin
            m_drop += nv - 1;
            if (q.size() >= DEPTH) m_drop++;
            else q.push_back(first);
         end
      end else begin
         q.delete();
      end
      if (m_drop > DROP_MAX) m_drop = DROP_MAX;
      if (m_inw) begin
         if (rdy) begin
            m_inw = 0;
            m_wv = 0;
            if (rej) m_err = 1;
         end
      end else if (pop) begin
         case (cmd)
            0: m_row = (m_row == 0) ? 8 : m_row - 1;
            1: m_row = (m_row + 1) % 9;
            2: m_col = (m_col == 0) ? 8 : m_col - 1;
            3: m_col = (m_col + 1) % 9;
            4: m_dig = m_dig % 9 + 1;
            5: m_dig = (m_dig == 1) ? 9 : m_dig - 1;
            6, 7: begin
               m_wr = m_row;
               m_wc = m_col;
               m_wd = (cmd == 6) ? m_dig : 0;
               m_wv = 1;
               m_inw = 1;
            end
            8: m_err = 0;
            default: ;
         endcase
      end
      m_blk = (!en || q.size() >= DEPTH - 1) ? 1 : 0;
   endtask

   task automatic step(input logic [11:0] btn, input bit en, input bit rdy,
                       input bit rej, input bit rst);
      btn_pulse = btn;
      enable    = en;
      wr_ready  = rdy;
      wr_reject = rej;
      reset     = rst;
      @(posedge clk);
      model_edge(btn, en, rdy, rej, rst);
      #1;
      check("cursor_row", cursor_row, m_row);
      check("cursor_col", cursor_col, m_col);
      check("sel_digit", sel_digit, m_dig);
      check("wr_valid", wr_valid, m_wv);
      check("wr_row", wr_row, m_wr);
      check("wr_col", wr_col, m_wc);
      check("wr_digit", wr_digit, m_wd);
      check("error_flag", error_flag, m_err);
      check("drop_count", drop_count, m_drop);
      check("block_controller", block_controller, m_blk);
      check("busy", busy, (m_inw || q.size() > 0) ? 1 : 0);
      $display("[TB] t=%0t btn=%03h en=%0b rdy=%0b rej=%0b rst=%0b -> row=%0d col=%0d dig=%0d wv=%0b wr=(%0d,%0d,%0d) err=%0b drop=%0d blk=%0b busy=%0b",
               $time, btn, en, rdy, rej, rst, cursor_row, cursor_col, sel_digit, wr_valid,
               wr_row, wr_col, wr_digit, error_flag, drop_count, block_controller, busy);
   endtask

   initial begin
      logic [11:0] rb;
      // Reset
      step(12'h000, 0, 0, 0, 0);
      step(12'h000, 0, 0, 0, 0);
      check("reset_block", block_controller, 1);
      check("reset_digit", sel_digit, 1);
      step(12'h000, 1, 0, 0, 1);

      // Right move visible two cycles after the pulse, then left wraps
      step(12'h008, 1, 0, 0, 1);
      check("right_latency_early", cursor_col, 0);
      step(12'h000, 1, 0, 0, 1);
      check("right_latency", cursor_col, 1);
      step(12'h004, 1, 0, 0, 1);
      step(12'h004, 1, 0, 0, 1);
      step(12'h000, 1, 0, 0, 1);
      check("left_wrap", cursor_col, 8);

      // Simultaneous up/digit+/place: only up wins
      step(12'h051, 1, 0, 0, 1);
      step(12'h000, 1, 0, 0, 1);
      check("arb_row", cursor_row, 8);
      check("arb_drop", drop_count, 2);

      // digit+ x3, place held off, rejected, then cleared
      for (int i = 0; i < 3; i++) step(12'h010, 1, 0, 0, 1);
      step(12'h000, 1, 0, 0, 1);
      check("digit_4", sel_digit, 4);
      step(12'h040, 1, 0, 0, 1);
      for (int i = 0; i < 5; i++) step(12'h000, 1, 0, 1, 1);
      check("place_valid", wr_valid, 1);
      check("place_digit", wr_digit, 4);
      step(12'h000, 1, 1, 1, 1);
      check("reject_valid", wr_valid, 0);
      check("reject_err", error_flag, 1);
      step(12'h100, 1, 0, 0, 1);
      step(12'h000, 1, 0, 0, 1);
      check("clear_err", error_flag, 0);

      // FIFO fills while a write stalls
      step(12'h040, 1, 0, 0, 1);
      step(12'h000, 1, 0, 0, 1);
      for (int i = 0; i < 5; i++) begin
         step(12'h008, 1, 0, 0, 1);
         if (i == 2) check("block_at_3", block_controller, 1);
      end
      check("full_drop", drop_count, 3);
      step(12'h000, 1, 1, 0, 1);
      for (int i = 0; i < 4; i++) step(12'h000, 1, 0, 0, 1);
      check("drain_col", cursor_col, 3);

      // Disable with queued commands and a pending write
      step(12'h040, 1, 0, 0, 1);
      step(12'h000, 1, 0, 0, 1);
      step(12'h008, 1, 0, 0, 1);
      step(12'h001, 1, 0, 0, 1);
      step(12'h000, 0, 0, 0, 1);
      check("dis_block", block_controller, 1);
      check("dis_busy", busy, 1);
      step(12'h1FF, 0, 0, 0, 1);
      check("dis_drop", drop_count, 3);
      step(12'h000, 0, 1, 0, 1);
      check("dis_write_done", wr_valid, 0);
      check("dis_idle", busy, 0);
      step(12'h000, 1, 0, 0, 1);

      // Reset in the middle of a write
      step(12'h080, 1, 0, 0, 1);
      step(12'h000, 1, 0, 0, 1);
      check("erase_valid", wr_valid, 1);
      step(12'h000, 1, 0, 0, 0);
      check("rst_wr_valid", wr_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_drop", drop_count, 0);
      step(12'h000, 1, 0, 0, 1);

      // Drop counter saturation
      for (int i = 0; i < 40; i++) step(12'h1FF, 1, 1, 1'($urandom_range(0, 1)), 1);
      check("drop_saturate", drop_count, DROP_MAX);
      for (int i = 0; i < 8; i++) step(12'h000, 1, 1, 0, 1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         rb = ($urandom_range(0, 2) == 0) ? 12'($urandom) : 12'h000;
         if (rb != 0 && $urandom_range(0, 1) == 1) rb = 12'h001 << $urandom_range(0, 11);
         step(rb, $urandom_range(0, 15) != 0, $urandom_range(0, 2) == 0,
              1'($urandom_range(0, 1)), $urandom_range(0, 99) != 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
